imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameters SHALL be: NB_DATA_BUS, default 32, word width; N_ADDRESS, default 128, memory depth in words; NB_ADDRESS, default $clog2(N_ADDRESS), address width; HALT_WORD, default 32'hFFFFFFFF, end-of-program marker.
REQ-002 Ports SHALL be, in order:
- i_clk, in, 1: single clock, all logic on posedge
- i_reset, in, 1: synchronous, active-high reset
- i_start, in, 1: begin program load
- i_rx_data, in, 8: received byte
- i_rx_valid, in, 1: i_rx_data valid this cycle, single-cycle pulse per byte
- o_w_addr, out, NB_ADDRESS: memory write address
- o_w_data, out, NB_DATA_BUS: memory write word
- o_w_en, out, 1: memory write strobe
- o_busy, out, 1: load in progress
- o_done, out, 1: load finished
- o_overflow, out, 1: memory filled without HALT_WORD
- o_n_words, out, NB_ADDRESS+1: words written
- o_checksum, out, NB_DATA_BUS: XOR of written words
REQ-003 Clock and reset SHALL be one clock (i_clk) and one synchronous, active-high reset (i_reset).

Function
REQ-004 The FSM SHALL have states IDLE, LOAD, WRITE and DONE.
REQ-005 In IDLE or DONE, i_start=1 SHALL enter LOAD next cycle and clear the byte counter, address, o_n_words, o_overflow, o_checksum and o_done.
REQ-006 Any i_rx_valid in the same cycle as i_start SHALL be ignored.
REQ-007 In LOAD, each i_rx_valid SHALL shift i_rx_data into the word assembler MSB-first, so the first byte lands in bits 31:24.
REQ-008 A 2-bit byte counter SHALL wrap from 3 to 0, and the 4th byte SHALL move the FSM to WRITE.
REQ-009 In WRITE, o_w_en SHALL be 1 for exactly one cycle with the assembled word on o_w_data and the current address on o_w_addr.
REQ-010 o_w_en, o_w_addr and o_w_data SHALL all be registered and stable for the whole cycle, so the memory samples them on the negedge.
REQ-011 i_rx_valid SHALL be ignored while the FSM is in WRITE, because the byte source guarantees at least 2 idle cycles between bytes.
REQ-012 After WRITE, o_n_words SHALL increment by 1.
REQ-013 After WRITE, if the word equals HALT_WORD, the FSM SHALL go to DONE; the halt word itself is written.
REQ-014 After WRITE, if the address equals N_ADDRESS-1 and the word is not HALT_WORD, the FSM SHALL go to DONE with o_overflow=1.
REQ-015 After WRITE, if neither REQ-013 nor REQ-014 applies, the address SHALL increment by 1 and the FSM SHALL return to LOAD.
REQ-016 o_busy SHALL be 1 in LOAD and WRITE only.
REQ-017 o_done SHALL be 1 in DONE only.
REQ-018 The address SHALL never wrap, and no write SHALL occur beyond N_ADDRESS-1.
REQ-019 In DONE, i_rx_valid SHALL be ignored, and o_n_words and o_overflow SHALL hold until the next i_start.
REQ-020 i_start during LOAD or WRITE SHALL be ignored.
REQ-021 A partial word (fewer than 4 bytes) SHALL never be written.

Reset
REQ-022 While i_reset=1, the FSM SHALL go to IDLE, and o_w_en, o_w_addr, o_w_data, o_busy, o_done, o_overflow, o_n_words and o_checksum SHALL all be 0; reset has priority over all other inputs.
REQ-023 A reset in any state, including WRITE, SHALL discard any partially assembled word, and no o_w_en SHALL be issued in the reset cycle.

Configuration
REQ-024 With macro IMEM_LOADER_CHECKSUM_EN defined, o_checksum SHALL XOR-accumulate every written word, including HALT_WORD, updating in the cycle after WRITE.
REQ-025 Without IMEM_LOADER_CHECKSUM_EN, o_checksum SHALL be constant 0 and no accumulator register SHALL exist.

Verification
REQ-026 Basic load: reset, i_start, then bytes 20 08 00 05 FF FF FF FF SHALL give writes addr0=32'h20080005 and addr1=32'hFFFFFFFF, then o_done=1, o_n_words=2, o_overflow=0.
REQ-027 Overflow: N_ADDRESS=4, 16 bytes of 8'h11 with no halt SHALL give 4 writes of 32'h11111111 at addr 0..3, then o_done=1, o_overflow=1, o_n_words=4, with no 5th write.
REQ-028 Reset mid-word: i_start, bytes AA BB, i_reset for 1 cycle SHALL give FSM in IDLE, no o_w_en, all outputs 0; a following i_start with FF FF FF FF SHALL write addr0=32'hFFFFFFFF.
REQ-029 Ignored inputs: i_start with i_rx_valid in the same cycle SHALL drop that byte; i_start mid-load SHALL not reset the address; bytes in DONE SHALL not write.
REQ-030 Checksum: with IMEM_LOADER_CHECKSUM_EN, words 32'h0000000F, 32'h000000F0 and HALT_WORD SHALL give o_checksum=32'hFFFFFF00; without the macro, o_checksum SHALL stay 0.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream program loader: packs bytes MSB-first into words and writes them to IMEM.
// Optional XOR checksum of written words when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int NB_DATA_BUS = 32,
  parameter int N_ADDRESS = 128,
  parameter int NB_ADDRESS = $clog2(N_ADDRESS),
  parameter logic [NB_DATA_BUS-1:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic [7:0]              i_rx_data,
  input  logic                    i_rx_valid,
  output logic [NB_ADDRESS-1:0]   o_w_addr,
  output logic [NB_DATA_BUS-1:0]  o_w_data,
  output logic                    o_w_en,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_overflow,
  output logic [NB_ADDRESS:0]     o_n_words,
  output logic [NB_DATA_BUS-1:0]  o_checksum
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [NB_ADDRESS-1:0] LAST_ADDR =
    NB_ADDRESS'(N_ADDRESS - 1);

  logic [1:0]             r_state;
  logic [1:0]             r_byte_cnt;
  logic [NB_DATA_BUS-1:0] r_word;
  logic [NB_ADDRESS-1:0]  r_addr;
  logic                   r_w_en;
  logic [NB_ADDRESS:0]    r_n_words;
  logic                   r_overflow;

  logic w_start;
  logic w_byte;
  logic w_halt;
  logic w_last;

  assign w_start = i_start && (r_state == IDLE || r_state == DONE);
  // A byte arriving together with i_start is always dropped.
  assign w_byte  = i_rx_valid && !i_start && (r_state == LOAD);
  assign w_halt  = (r_word == HALT_WORD);
  assign w_last  = (r_addr == LAST_ADDR);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_byte_cnt <= '0;
      r_word     <= '0;
      r_addr     <= '0;
      r_w_en     <= 1'b0;
      r_n_words  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_w_en <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (w_start) begin
            r_state    <= LOAD;
            r_byte_cnt <= '0;
            r_word     <= '0;
            r_addr     <= '0;
            r_n_words  <= '0;
            r_overflow <= 1'b0;
          end
        end
        LOAD: begin
          if (w_byte) begin
            r_word     <= {r_word[NB_DATA_BUS-9:0], i_rx_data};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_state <= WRITE;
              r_w_en  <= 1'b1;
            end
          end
        end
        WRITE: begin
          r_n_words <= r_n_words + 1'b1;
          if (w_halt) begin
            r_state <= DONE;
          end else if (w_last) begin
            r_state    <= DONE;
            r_overflow <= 1'b1;
          end else begin
            r_addr  <= r_addr + 1'b1;
            r_state <= LOAD;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Address and word registers stay frozen through WRITE, so they drive the bus directly.
  assign o_w_addr   = r_addr;
  assign o_w_data   = r_word;
  assign o_w_en     = r_w_en;
  assign o_busy     = (r_state == LOAD) || (r_state == WRITE);
  assign o_done     = (r_state == DONE);
  assign o_overflow = r_overflow;
  assign o_n_words  = r_n_words;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [NB_DATA_BUS-1:0] r_checksum;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_checksum <= '0;
    end else if (w_start) begin
      r_checksum <= '0;
    end else if (r_state == WRITE) begin
      r_checksum <= r_checksum ^ r_word;
    end
  end

  assign o_checksum = r_checksum;
`else
  assign o_checksum = '0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized bench for imem_loader with a word-level reference model.
// Follows IMEM_LOADER_CHECKSUM_EN to pick the expected checksum behaviour.
module tb_imem_loader;

  localparam int NB_DATA_BUS = 32;
  localparam int N_ADDRESS = 4;
  localparam int NB_ADDRESS = $clog2(N_ADDRESS);
  localparam logic [31:0] HALT = 32'hFFFFFFFF;

  logic                   i_clk = 1'b0;
  logic                   i_reset = 1'b0;
  logic                   i_start = 1'b0;
  logic [7:0]             i_rx_data = 8'h00;
  logic                   i_rx_valid = 1'b0;
  logic [NB_ADDRESS-1:0]  o_w_addr;
  logic [NB_DATA_BUS-1:0] o_w_data;
  logic                   o_w_en;
  logic                   o_busy;
  logic                   o_done;
  logic                   o_overflow;
  logic [NB_ADDRESS:0]    o_n_words;
  logic [NB_DATA_BUS-1:0] o_checksum;

  imem_loader #(
    .NB_DATA_BUS(NB_DATA_BUS),
    .N_ADDRESS(N_ADDRESS),
    .NB_ADDRESS(NB_ADDRESS),
    .HALT_WORD(HALT)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_start(i_start),
    .i_rx_data(i_rx_data),
    .i_rx_valid(i_rx_valid),
    .o_w_addr(o_w_addr),
    .o_w_data(o_w_data),
    .o_w_en(o_w_en),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_overflow(o_overflow),
    .o_n_words(o_n_words),
    .o_checksum(o_checksum)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] got_a[$];
  logic [31:0] got_d[$];
  logic [31:0] exp_a[$];
  logic [31:0] exp_d[$];
  logic [31:0] words[$];
  logic        exp_ovf;
  logic [31:0] exp_cks;

  // Write monitor: o_w_en is registered, so one negedge sample per strobe.
  always @(negedge i_clk) begin
    if (o_w_en === 1'b1) begin
      got_a.push_back(32'(o_w_addr));
      got_d.push_back(o_w_data);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    got_a.delete();
    got_d.delete();
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_reset = 1'b1;
    i_start = 1'b1;
    i_rx_valid = 1'b1;
    @(negedge i_clk);
    chk("rst_w_en", 64'(o_w_en), 64'd0);
    chk("rst_addr", 64'(o_w_addr), 64'd0);
    chk("rst_data", 64'(o_w_data), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_ovf", 64'(o_overflow), 64'd0);
    chk("rst_nw", 64'(o_n_words), 64'd0);
    chk("rst_cks", 64'(o_checksum), 64'd0);
    i_reset = 1'b0;
    i_start = 1'b0;
    i_rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge i_clk);
    i_rx_data = b;
    i_rx_valid = 1'b1;
    @(negedge i_clk);
    i_rx_valid = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8]);
  endtask

  // Reference: words are stored in order until the halt word or the memory is full.
  task automatic model();
    exp_a.delete();
    exp_d.delete();
    exp_ovf = 1'b0;
    exp_cks = 32'h0;
    foreach (words[i]) begin
      if (exp_d.size() == N_ADDRESS) begin
        exp_ovf = 1'b1;
        break;
      end
      exp_a.push_back(32'(i));
      exp_d.push_back(words[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
      exp_cks = exp_cks ^ words[i];
`endif
      if (words[i] == HALT) break;
    end
    if (exp_d.size() == N_ADDRESS && exp_d[N_ADDRESS-1] != HALT)
      exp_ovf = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (o_done !== 1'b1 && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    chk({tag, "_done"}, 64'(o_done), 64'd1);
  endtask

  task automatic check_result(input string tag);
    wait_done(tag);
    chk({tag, "_nwr"}, 64'(got_d.size()), 64'(exp_d.size()));
    foreach (exp_d[i]) begin
      if (i < got_d.size()) begin
        chk({tag, "_addr"}, 64'(got_a[i]), 64'(exp_a[i]));
        chk({tag, "_data"}, 64'(got_d[i]), 64'(exp_d[i]));
      end
    end
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
    chk({tag, "_nw"}, 64'(o_n_words), 64'(exp_d.size()));
    chk({tag, "_ovf"}, 64'(o_overflow), 64'(exp_ovf));
    chk({tag, "_cks"}, 64'(o_checksum), 64'(exp_cks));
  endtask

  task automatic run_words(input string tag);
    model();
    clear_mon();
    pulse_start();
    chk({tag, "_busy_ld"}, 64'(o_busy), 64'd1);
    foreach (words[i]) send_word(words[i]);
    check_result(tag);
  endtask

  initial begin
    do_reset();

    // basic load
    words = '{32'h20080005, HALT};
    run_words("basic");

    // overflow, then extra bytes while in DONE must not write
    words = '{32'h11111111, 32'h11111111, 32'h11111111,
              32'h11111111, 32'h11111111};
    run_words("ovf");
    chk("ovf_val", 64'(o_overflow), 64'd1);

    // reset in the middle of a word
    clear_mon();
    pulse_start();
    send_byte(8'hAA);
    send_byte(8'hBB);
    do_reset();
    chk("midrst_nwr", 64'(got_d.size()), 64'd0);
    words = '{HALT};
    run_words("midrst");

    // byte coinciding with i_start is dropped
    words = '{32'h01020304, HALT};
    model();
    clear_mon();
    @(negedge i_clk);
    i_start = 1'b1;
    i_rx_valid = 1'b1;
    i_rx_data = 8'hEE;
    @(negedge i_clk);
    i_start = 1'b0;
    i_rx_valid = 1'b0;
    foreach (words[i]) send_word(words[i]);
    check_result("stvld");

    // i_start mid-load neither restarts nor clears the address
    words = '{32'h00000001, 32'h00000002, HALT};
    model();
    clear_mon();
    pulse_start();
    send_word(32'h00000001);
    send_byte(8'h00);
    send_byte(8'h00);
    pulse_start();
    chk("midst_busy", 64'(o_busy), 64'd1);
    send_byte(8'h00);
    send_byte(8'h02);
    send_word(HALT);
    check_result("midst");

    // checksum pattern
    words = '{32'h0000000F, 32'h000000F0, HALT};
    run_words("cks");
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("cks_val", 64'(o_checksum), 64'hFFFFFF00);
`else
    chk("cks_val", 64'(o_checksum), 64'h0);
`endif

    // randomized programs, occasionally containing the halt word
    for (int it = 0; it < 20; it++) begin
      words.delete();
      for (int j = 0; j < 6; j++) begin
        if ($urandom_range(0, 3) == 0) words.push_back(HALT);
        else words.push_back($urandom);
      end
      run_words("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
